seg7_scan_controller: RTL and testbench
=======================================

# seg7_scan_controller

Time-multiplexing scan controller for the 4-digit common-anode 7-segment display. It takes the 16-bit value from `counter16` and shares the display's segment bus among four digits, one digit at a time. Each digit is lit for a fixed on-time and followed by a blanking gap to suppress ghosting. The count is snapshotted once per frame so a frame never mixes digits from two count values. The block sits between `counter16` and the board's anode and segment pins.

## Interface
- `DIGIT_CYCLES`, default 100000: clock cycles each digit is lit (1 ms at 100 MHz). Must be ≥1.
- `BLANK_CYCLES`, default 1000: clock cycles all anodes are off after each digit. Must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `count`  in  16  value to display. Nibble k drives digit k (digit 0 = `count[3:0]`, rightmost).
- `enable`  in  1  scan enable, level-sensitive.
- `lz_blank`  in  1  1 = blank leading zeros.
- `dp_mask`  in  4  per-digit decimal point request (bit k = digit k).
- `an`  out  4  anode enables, active-low, one-hot-low or all-high.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse at the end of each completed frame.

## Operation
- Reset (asynchronous, takes effect immediately):
  - outputs: `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `frame_done`=0.
  - internal: state IDLE, digit index 0, timer 0, snapshot 0.
- FSM states: IDLE, ON, BLANK.
  - **IDLE**: all anodes off. On an edge with `enable`=1, capture `snap<=count`, set digit=0, enter ON.
  - **ON**: `an[digit]`=0 (unless leading-zero blanked). `seg`=hex decode of `snap[4*digit+:4]`. `dp`=~`dp_mask[digit]`. Lasts exactly DIGIT_CYCLES cycles, then enter BLANK.
  - **BLANK**: `an`=4'b1111, `seg`=7'b1111111, `dp`=1. Lasts exactly BLANK_CYCLES cycles. At the end:
    - digit<3: digit+1, enter ON.
    - digit==3: pulse `frame_done` and set digit=0. If `enable`=1, re-snapshot `count` and enter ON; otherwise enter IDLE.
- `enable`=0 seen in ON or BLANK: enter IDLE at that edge, with all outputs off from that edge on. No `frame_done` pulse; the partial frame is abandoned.
- Hex decode, active-low, `{g..a}`:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110
- Leading-zero blanking (`lz_blank`=1):
  - Digit k (k=1..3) is blanked when `snap` nibbles k..3 are all zero.
  - A blanked digit keeps `an`=1111, `seg`=1111111 and `dp`=1 for its ON slot, with slot timing unchanged.
  - Digit 0 is never blanked.
  - `lz_blank` and `dp_mask` are sampled live, not snapshotted.
- All outputs are registered, with no combinational path from any input to any output. The timer is an internal counter sized to max(DIGIT_CYCLES, BLANK_CYCLES).

## Timing
- Let E be the first edge with `enable`=1 in IDLE.
  - `an`=1110 from E through E+DIGIT_CYCLES−1.
  - `an`=1111 for the next BLANK_CYCLES cycles.
  - Digits 1, 2 and 3 follow in the same pattern.
- Frame period is 4×(DIGIT_CYCLES+BLANK_CYCLES) cycles, with no idle gap between frames while `enable` stays 1.
- `frame_done` is high for exactly the cycle after the last BLANK cycle of digit 3. That cycle coincides with digit 0 ON of the next frame, or with the first IDLE cycle.
- The snapshot is taken at E and at each frame boundary. Changes to `count` mid-frame become visible in the next frame only.
- Output latency: the new `an`, `seg` and `dp` values appear at the same edge where the state or digit changes.

## Test plan
All scenarios use DIGIT_CYCLES=4, BLANK_CYCLES=2 (24-cycle frame).
- **Reset**: assert `reset_n`=0 mid-ON, between clock edges → `an`=1111, `seg`=1111111, `dp`=1 and `frame_done`=0 immediately. After release, outputs stay off until `enable`=1.
- **Scan order**: `count`=16'h1A8F, `enable`=1, `lz_blank`=0 → output sequence:
  - `an`=1110 with `seg`=0001110 for 4 cycles, then 1111 for 2 cycles;
  - 1101 with 0000000 (8); 1011 with 0001000 (A); 0111 with 1111001 (1);
  - `frame_done`=1 on cycle 24 after E, with `an`=1110 again in the same cycle.
- **Snapshot**: `count`=16'h1234 at E, changed to 16'h5678 at E+10 → frame 1 shows 4,3,2,1; frame 2 shows 8,7,6,5.
- **Leading-zero blanking**, `lz_blank`=1:
  - `count`=16'h0005 → `an[3:1]` never 0; digit 0 shows `seg`=0010010.
  - `count`=16'h0000 → only digit 0 is lit, showing 1000000.
  - `count`=16'h0500 → digits 0, 1 and 2 are lit; digit 3 is blanked.
- **Enable drop**: `enable`=0 during digit 2 ON → next edge `an`=1111, IDLE, no `frame_done`. Re-enable restarts at digit 0 with a fresh snapshot.
- **Decimal point**: `dp_mask`=4'b0010 → `dp`=0 only during digit 1 ON slots, 1 at all other times including BLANK.

Source files
------------

// File: rtl/seg7_scan_controller_if.sv
// rtl/seg7_scan_controller_if.sv - Signal bundle between count source, scan controller and display pins
//
// Purpose: groups the display-facing and count-facing signals of seg7_scan_controller.
// Signals:
//   count      [15:0]  value to display, nibble k -> digit k (digit 0 rightmost)
//   enable             scan enable, level-sensitive
//   lz_blank           1 = blank leading zeros
//   dp_mask    [3:0]   per-digit decimal point request
//   an         [3:0]   anode enables, active-low
//   seg        [6:0]   segments {g,f,e,d,c,b,a}, active-low
//   dp                 decimal point, active-low
//   frame_done         one-cycle pulse after each completed frame
// Modports:
//   master  drives count/enable/lz_blank/dp_mask, observes the display outputs
//   slave   the scan controller side
interface seg7_scan_controller_if;
  logic [15:0] count;
  logic        enable;
  logic        lz_blank;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output count, enable, lz_blank, dp_mask,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  count, enable, lz_blank, dp_mask,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - 4-digit common-anode 7-segment time-multiplexing scan controller
//
// Purpose: lights one digit at a time for DIGIT_CYCLES clocks, then blanks all
// anodes for BLANK_CYCLES clocks, cycling digits 0..3. The count is snapshotted
// at scan start and at every frame boundary so a frame never mixes two values.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of seg7_scan_controller_if
//            (count, enable, lz_blank, dp_mask in; an, seg, dp, frame_done out)
// All outputs are registered; no combinational input-to-output path.
module seg7_scan_controller #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  seg7_scan_controller_if.slave   bus
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] T_DIGIT_LAST = TW'(DIGIT_CYCLES - 1);
  localparam logic [TW-1:0] T_BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] T_ZERO       = '0;
  localparam logic [TW-1:0] T_ONE        = TW'(1);

  // Packed output word {an[3:0], seg[6:0], dp}; all-ones is "everything off".
  localparam logic [11:0] OUT_OFF = 12'hFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_digit;
  logic [TW-1:0]   r_timer;
  logic [15:0]     r_snap;
  logic [11:0]     r_out;
  logic            r_frame_done;

  // Active-low hex decode, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Output word for digit d lit from value s. Digit d (d>0) is a leading zero
  // when nibbles d..3 are all zero, i.e. s shifted right by 4*d is zero.
  function automatic logic [11:0] on_pattern(
    input logic [15:0] s,
    input logic [1:0]  d,
    input logic        lz,
    input logic [3:0]  dpm
  );
    logic [3:0] nib;
    logic       hide;
    nib  = s[4*d +: 4];
    hide = lz && (d != 2'd0) && ((s >> (4*d)) == 16'd0);
    if (hide) begin
      on_pattern = OUT_OFF;
    end else begin
      on_pattern = {~(4'b0001 << d), hex7(nib), ~dpm[d]};
    end
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_digit      <= 2'd0;
      r_timer      <= T_ZERO;
      r_snap       <= 16'd0;
      r_out        <= OUT_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_digit <= 2'd0;
          r_timer <= T_ZERO;
          if (bus.enable) begin
            // Outputs come straight from count here since r_snap loads on this same edge.
            r_snap  <= bus.count;
            r_state <= S_ON;
            r_out   <= on_pattern(bus.count, 2'd0, bus.lz_blank, bus.dp_mask);
          end else begin
            r_out   <= OUT_OFF;
          end
        end

        S_ON: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
            r_digit <= 2'd0;
            r_timer <= T_ZERO;
            r_out   <= OUT_OFF;
          end else if (r_timer == T_DIGIT_LAST) begin
            r_state <= S_BLANK;
            r_timer <= T_ZERO;
            r_out   <= OUT_OFF;
          end else begin
            r_timer <= r_timer + T_ONE;
            // Re-evaluated every cycle so lz_blank and dp_mask act live.
            r_out   <= on_pattern(r_snap, r_digit, bus.lz_blank, bus.dp_mask);
          end
        end

        S_BLANK: begin
          if (r_timer == T_BLANK_LAST) begin
            r_timer <= T_ZERO;
            if (r_digit != 2'd3) begin
              if (bus.enable) begin
                r_digit <= r_digit + 2'd1;
                r_state <= S_ON;
                r_out   <= on_pattern(r_snap, r_digit + 2'd1, bus.lz_blank, bus.dp_mask);
              end else begin
                r_digit <= 2'd0;
                r_state <= S_IDLE;
                r_out   <= OUT_OFF;
              end
            end else begin
              // The frame is complete once digit 3's gap has elapsed, so it is
              // reported even if enable falls on this very edge.
              r_frame_done <= 1'b1;
              r_digit      <= 2'd0;
              if (bus.enable) begin
                r_snap  <= bus.count;
                r_state <= S_ON;
                r_out   <= on_pattern(bus.count, 2'd0, bus.lz_blank, bus.dp_mask);
              end else begin
                r_state <= S_IDLE;
                r_out   <= OUT_OFF;
              end
            end
          end else if (!bus.enable) begin
            r_state <= S_IDLE;
            r_digit <= 2'd0;
            r_timer <= T_ZERO;
            r_out   <= OUT_OFF;
          end else begin
            r_timer <= r_timer + T_ONE;
            r_out   <= OUT_OFF;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_digit <= 2'd0;
          r_timer <= T_ZERO;
          r_out   <= OUT_OFF;
        end
      endcase
    end
  end

  assign bus.an         = r_out[11:8];
  assign bus.seg        = r_out[7:1];
  assign bus.dp         = r_out[0];
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - Directed self-checking bench for seg7_scan_controller
module tb_seg7_scan_controller;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  seg7_scan_controller_if bus_if ();

  seg7_scan_controller #(
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low {g..a} patterns for hex digits 0..F.
  logic [6:0] hex_t [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, " an"},  {12'd0, bus_if.an},  16'h000F);
    chk({tag, " seg"}, {9'd0, bus_if.seg},  16'h007F);
    chk({tag, " dp"},  {15'd0, bus_if.dp},  16'h0001);
    chk({tag, " fd"},  {15'd0, bus_if.frame_done}, 16'h0000);
  endtask

  // Checks one 24-cycle frame starting at the next rising edge.
  // lit: hand-computed mask of digits that light (not leading-zero blanked).
  // chg_at: cycle after which count is changed to chg_val (-1 = never).
  // stop_at: cycle after which enable drops; then 12 off cycles are checked.
  task automatic check_frame(
    input string       name,
    input logic [15:0] val,
    input logic [3:0]  lit,
    input logic [3:0]  dpm,
    input logic        fd_first,
    input int          chg_at,
    input logic [15:0] chg_val,
    input int          stop_at
  );
    logic [3:0] one;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;
    int         slot;
    int         pos;
    logic       on;
    one = 4'b0001;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      slot  = i / 6;
      pos   = i % 6;
      on    = (pos < 4) && lit[slot];
      e_an  = on ? ~(one << slot) : 4'hF;
      e_seg = on ? hex_t[val[4*slot +: 4]] : 7'h7F;
      e_dp  = on ? ~dpm[slot] : 1'b1;
      e_fd  = (i == 0) ? fd_first : 1'b0;
      chk($sformatf("%s an c%0d", name, i),  {12'd0, bus_if.an},  {12'd0, e_an});
      chk($sformatf("%s seg c%0d", name, i), {9'd0, bus_if.seg},  {9'd0, e_seg});
      chk($sformatf("%s dp c%0d", name, i),  {15'd0, bus_if.dp},  {15'd0, e_dp});
      chk($sformatf("%s fd c%0d", name, i),  {15'd0, bus_if.frame_done}, {15'd0, e_fd});
      if (i == chg_at) bus_if.count = chg_val;
      if (i == stop_at) begin
        bus_if.enable = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          chk_off($sformatf("%s stopped k%0d", name, k));
        end
        return;
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n         = 1'b0;
    bus_if.count    = 16'h0000;
    bus_if.enable   = 1'b0;
    bus_if.lz_blank = 1'b0;
    bus_if.dp_mask  = 4'b0000;

    // Reset state and idle-until-enable.
    repeat (3) @(negedge clk);
    chk_off("reset");
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_off($sformatf("idle k%0d", k));
    end

    // Scan order, then live dp_mask on the following frame.
    bus_if.count  = 16'h1A8F;
    bus_if.enable = 1'b1;
    check_frame("scan1", 16'h1A8F, 4'b1111, 4'b0000, 1'b0, -1, 16'h0, -1);
    bus_if.dp_mask = 4'b0010;
    check_frame("dp", 16'h1A8F, 4'b1111, 4'b0010, 1'b1, -1, 16'h0, 20);
    bus_if.dp_mask = 4'b0000;

    // Snapshot: mid-frame count change appears only in the next frame.
    bus_if.count  = 16'h1234;
    bus_if.enable = 1'b1;
    check_frame("snap1", 16'h1234, 4'b1111, 4'b0000, 1'b0, 10, 16'h5678, -1);
    check_frame("snap2", 16'h5678, 4'b1111, 4'b0000, 1'b1, -1, 16'h0, 2);

    // Leading-zero blanking.
    bus_if.lz_blank = 1'b1;
    bus_if.count    = 16'h0005;
    bus_if.enable   = 1'b1;
    check_frame("lz0005", 16'h0005, 4'b0001, 4'b0000, 1'b0, 23, 16'h0000, -1);
    check_frame("lz0000", 16'h0000, 4'b0001, 4'b0000, 1'b1, 23, 16'h0500, -1);
    check_frame("lz0500", 16'h0500, 4'b0111, 4'b0000, 1'b1, -1, 16'h0, 20);
    bus_if.lz_blank = 1'b0;

    // Enable drop during digit 2 ON, then restart with a fresh snapshot.
    bus_if.count  = 16'h4321;
    bus_if.enable = 1'b1;
    check_frame("drop", 16'h4321, 4'b1111, 4'b0000, 1'b0, 12, 16'hBEEF, 13);
    bus_if.enable = 1'b1;
    check_frame("restart", 16'hBEEF, 4'b1111, 4'b0000, 1'b0, -1, 16'h0, 8);

    // Asynchronous reset mid-ON, between clock edges.
    bus_if.count  = 16'h0F0F;
    bus_if.enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre-reset an", {12'd0, bus_if.an}, 16'h000E);
    #2 reset_n = 1'b0;
    #1 chk_off("async reset");
    bus_if.enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_off($sformatf("post-reset k%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
